// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, FSM encoding and constants
//
// Contents:
//   aes_state_t      128-bit AES state; byte i = bits [127-8i -: 8], byte 0 = MSB
//   aes_byte_t       one state byte
//   fsm_state_t      sequencer states IDLE / RUN / DONE
//   AES_STATE_BYTES  bytes per state (16)
package aes_pkg;

    localparam int AES_STATE_BYTES = 16;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fwd_sbox.sv
// rtl/fwd_sbox.sv - combinational AES forward S-box lookup (used only with SUBBYTES_FWD_EN)
//
// Ports:
//   a  in  8  byte to substitute
//   y  out 8  SBox(a)
module fwd_sbox
    import aes_pkg::*;
(
    input  aes_byte_t a,
    output aes_byte_t y
);

    localparam aes_byte_t TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = TABLE[a];

endmodule

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box lookup
//
// Ports:
//   a  in  8  byte to substitute
//   y  out 8  InvSBox(a)
module inv_sbox
    import aes_pkg::*;
(
    input  aes_byte_t a,
    output aes_byte_t y
);

    localparam aes_byte_t TABLE [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign y = TABLE[a];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - AES InvSubBytes over a 128-bit state, LANES bytes per cycle
//
// Parameter LANES (1,2,4,8,16): shared S-box instances; STEPS = 16/LANES cycles per state.
// Optional macro SUBBYTES_FWD_EN adds port fwd selecting the forward S-box per operation.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous reset, active-high
//   fwd        in   1    (SUBBYTES_FWD_EN only) 1 = forward S-box, sampled at input handshake
//   in_valid   in   1    input state valid
//   in_ready   out  1    block can accept a state (IDLE)
//   in_data    in   128  input state, byte 0 = MSB
//   out_valid  out  1    result valid (DONE)
//   out_ready  in   1    downstream accepts result
//   out_data   out  128  substituted state, same byte order
//   busy       out  1    high in RUN or DONE
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SUBBYTES_FWD_EN
    input  logic         fwd,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int STEPS = AES_STATE_BYTES / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    fsm_state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    aes_state_t work;
    aes_state_t work_next;
    aes_byte_t  work_b [AES_STATE_BYTES];
    aes_byte_t  lane_in  [LANES];
    aes_byte_t  lane_out [LANES];
    logic [3:0] idx;
    logic       last_step;

    assign last_step = (cnt == CNT_W'(STEPS - 1));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // Byte view of the working register so lanes can index by byte number.
    always_comb begin
        for (int i = 0; i < AES_STATE_BYTES; i++) begin
            work_b[i] = work[127 - 8*i -: 8];
        end
    end

    // Lane j handles byte cnt*LANES + j; results are written back in place.
    always_comb begin
        idx       = '0;
        work_next = work;
        for (int j = 0; j < LANES; j++) begin
            idx        = 4'(int'(cnt) * LANES + j);
            lane_in[j] = work_b[idx];
            if (state == RUN) begin
                work_next[127 - 8*int'(idx) -: 8] = lane_out[j];
            end
        end
    end

`ifdef SUBBYTES_FWD_EN
    logic fwd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            fwd_q <= fwd;
        end
    end

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            aes_byte_t inv_y, fwd_y;
            inv_sbox u_inv (.a(lane_in[j]), .y(inv_y));
            fwd_sbox u_fwd (.a(lane_in[j]), .y(fwd_y));
            assign lane_out[j] = fwd_q ? fwd_y : inv_y;
        end
    endgenerate
`else
    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            inv_sbox u_inv (.a(lane_in[j]), .y(lane_out[j]));
        end
    endgenerate
`endif

    // Datapath: working register and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_data;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    work <= work_next;
                    cnt  <= last_step ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_data = work;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - self-checking bench for inv_sub_bytes_seq
module tb_inv_sub_bytes_seq;

    localparam int LANES = 4;
    localparam int STEPS = 16 / LANES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef SUBBYTES_FWD_EN
    logic         fwd;
`endif

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(LANES)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SUBBYTES_FWD_EN
        .fwd(fwd),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from the field inverse plus affine map; inverse table by inversion.
    task automatic build_tables();
        logic [7:0] inv_e, s;
        for (int x = 0; x < 256; x++) begin
            inv_e = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv_e = 8'(y);
            end
            s = inv_e ^ rotl(inv_e, 1) ^ rotl(inv_e, 2) ^ rotl(inv_e, 3) ^ rotl(inv_e, 4) ^ 8'h63;
            ref_fwd[x] = s;
            ref_inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] map_state(input logic [127:0] st, input bit use_fwd);
        logic [127:0] r;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = st[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = use_fwd ? ref_fwd[b] : ref_inv[b];
        end
        return r;
    endfunction

    // Behavioural model: 0 = accepting, 1 = working (m_left cycles to go), 2 = presenting.
    int           m_phase = 0;
    int           m_left = 0;
    logic [127:0] m_res = '0;

    always @(posedge clk) begin
        bit use_fwd;
        use_fwd = 1'b0;
`ifdef SUBBYTES_FWD_EN
        use_fwd = fwd;
`endif
        if (rst) begin
            m_phase = 0;
            m_res   = '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res   = map_state(in_data, use_fwd);
                    m_left  = STEPS;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", {127'd0, in_ready}, {127'd0, m_phase == 0});
            check("out_valid", {127'd0, out_valid}, {127'd0, m_phase == 2});
            check("busy", {127'd0, busy}, {127'd0, m_phase != 0});
            if (m_phase == 2) check("out_data", out_data, m_res);
        end
    end

    task automatic send(input logic [127:0] d, input bit f);
        bit sent;
        sent = 1'b0;
        for (int c = 0; c < 200 && !sent; c++) begin
            @(negedge clk);
            if (in_ready) begin
                in_valid = 1'b1;
                in_data  = d;
`ifdef SUBBYTES_FWD_EN
                fwd = f;
`endif
                sent = 1'b1;
            end
        end
        if (!sent) check("send_timeout", 128'd0, 128'd1);
        if (f) in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {4{$urandom}};
    endtask

    // Called right after send(): counts cycles from the handshake until out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("wait_out_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        int lat;
        logic [127:0] held;
        logic [127:0] st;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef SUBBYTES_FWD_EN
        fwd = 1'b0;
`endif
        build_tables();

        check("ref_inv_63", {120'd0, ref_inv[8'h63]}, 128'h00);
        check("ref_inv_7c", {120'd0, ref_inv[8'h7c]}, 128'h01);
        check("ref_inv_16", {120'd0, ref_inv[8'h16]}, 128'hff);
        check("ref_inv_00", {120'd0, ref_inv[8'h00]}, 128'h52);
        check("ref_inv_52", {120'd0, ref_inv[8'h52]}, 128'h48);
        check("ref_fwd_00", {120'd0, ref_fwd[8'h00]}, 128'h63);

        repeat (2) @(negedge clk);
        check("reset_out_data", out_data, 128'd0);
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        cmp_en = 1'b1;
        rst = 1'b0;

        // All 0x63 -> all 0x00, with latency and backpressure checks.
        send({16{8'h63}}, 1'b0);
        wait_out(lat);
        check("latency_63", 128'(lat), 128'(1 + STEPS));
        check("data_63", out_data, 128'd0);
        held = out_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid", {127'd0, out_valid}, 128'd1);
            check("bp_data", out_data, held);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", {127'd0, out_valid}, 128'd0);
        check("release_in_ready", {127'd0, in_ready}, 128'd1);

        // Boundary bytes.
        send({8'h00, 8'h7c, 8'h16, 8'h52, {12{8'h63}}}, 1'b0);
        wait_out(lat);
        check("latency_boundary", 128'(lat), 128'(1 + STEPS));
        check("data_boundary", out_data, {8'h52, 8'h01, 8'hff, 8'h48, 96'd0});

        // Every byte value once, sixteen states.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = 8'(16*k + i);
            send(st, 1'b0);
            wait_out(lat);
            check("latency_table", 128'(lat), 128'(1 + STEPS));
        end

        // Reset partway through RUN.
        @(negedge clk);
        send({4{$urandom}}, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        check("midrst_busy", {127'd0, busy}, 128'd0);
        check("midrst_out_data", out_data, 128'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("midrst_no_valid", {127'd0, out_valid}, 128'd0);
        end
        send({8'h00, 8'h7c, 8'h16, 8'h52, {12{8'h63}}}, 1'b0);
        wait_out(lat);
        check("after_rst_data", out_data, {8'h52, 8'h01, 8'hff, 8'h48, 96'd0});

`ifdef SUBBYTES_FWD_EN
        send(128'd0, 1'b1);
        wait_out(lat);
        check("fwd_zero", out_data, {16{8'h63}});
        held = out_data;
        send(held, 1'b0);
        wait_out(lat);
        check("fwd_roundtrip", out_data, 128'd0);
`endif

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = $urandom_range(0, 2) != 0;
            rst       = $urandom_range(0, 63) == 0;
`ifdef SUBBYTES_FWD_EN
            fwd = $urandom_range(0, 1) == 1;
`endif
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (STEPS + 4) @(negedge clk);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
